// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state/cause encodings and constants for the pipeline controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MEM      = 2'd1,
    CAUSE_REDIRECT = 2'd2,
    CAUSE_LOADUSE  = 2'd3
  } stall_cause_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use comparator between ID sources and EX load rd
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid_i,
  input  logic              ex_valid_i,
  input  logic              ex_is_load_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  output logic              loaduse_o
);

  logic load_in_ex;
  logic src_match;

  // x0 is hardwired to zero, so a load targeting it never produces a usable value
  assign load_in_ex = id_valid_i & ex_valid_i & ex_is_load_i & ex_reg_write_i & (ex_rd_i != '0);
  assign src_match  = (id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i));
  assign loaduse_o  = load_in_ex & src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 4-stage pipeline sequencer: PC, stage valids, latch enables, hazards (PIPE_CTRL_PERF_EN adds counters)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              dmem_busy,
  output logic [XLEN-1:0]   pc,
  output logic              id_en,
  output logic              ex_en,
  output logic              wb_en,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              wb_valid,
  output logic [1:0]        stall_cause
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush
`endif
);

  pipe_state_t     state_q, state_d;
  stall_cause_t    cause;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic            ex_valid_q, ex_valid_d;
  logic            wb_valid_q, wb_valid_d;
  logic            mem_stall, redirect, loaduse;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_valid_i     (id_valid_q),
    .ex_valid_i     (ex_valid_q),
    .ex_is_load_i   (ex_is_load),
    .ex_reg_write_i (ex_reg_write),
    .ex_rd_i        (ex_rd),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_use_rs1_i   (id_use_rs1),
    .id_use_rs2_i   (id_use_rs2),
    .loaduse_o      (loaduse)
  );

  assign mem_stall = ex_valid_q & dmem_busy;
  assign redirect  = ex_valid_q & ex_redirect;

  always_comb begin
    cause      = CAUSE_NONE;
    id_en      = 1'b1;
    ex_en      = 1'b1;
    wb_en      = 1'b1;
    pc_d       = pc_q;
    id_valid_d = imem_valid;
    ex_valid_d = id_valid_q;
    wb_valid_d = ex_valid_q;
    if (mem_stall) begin
      cause      = CAUSE_MEM;
      id_en      = 1'b0;
      ex_en      = 1'b0;
      wb_en      = 1'b0;
      id_valid_d = id_valid_q;
      ex_valid_d = ex_valid_q;
      wb_valid_d = 1'b0;
    end else if (redirect) begin
      cause      = CAUSE_REDIRECT;
      pc_d       = {ex_target[XLEN-1:1], 1'b0};
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
      wb_valid_d = 1'b1;
    end else if (loaduse) begin
      // hold IF/ID, push a bubble into EX while the load moves on to WB
      cause      = CAUSE_LOADUSE;
      id_en      = 1'b0;
      id_valid_d = id_valid_q;
      ex_valid_d = 1'b0;
      wb_valid_d = 1'b1;
    end else if (imem_valid) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_comb begin
    state_d = ST_RUN;
    unique case (state_q)
      // EX is always empty right after a flush, so no event can fire here
      ST_REDIRECT: state_d = ST_RUN;
      default: begin
        if (mem_stall)     state_d = ST_MEM_WAIT;
        else if (redirect) state_d = ST_REDIRECT;
        else               state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      ex_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      ex_valid_q <= ex_valid_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign pc          = pc_q;
  assign id_valid    = id_valid_q;
  assign ex_valid    = ex_valid_q;
  assign wb_valid    = wb_valid_q;
  assign stall_cause = cause;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] retired_q, stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      if (wb_valid_q && retired_q != '1) retired_q <= retired_q + 32'd1;
      if ((cause == CAUSE_MEM || cause == CAUSE_LOADUSE) && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (cause == CAUSE_REDIRECT && flush_q != '1) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
  assign perf_flush   = flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - table-driven self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load, ex_redirect, dmem_busy;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        id_en, ex_en, wb_en, id_valid, ex_valid, wb_valid;
  logic [1:0]  stall_cause;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_retired, perf_stall, perf_flush;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .imem_valid(imem_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .dmem_busy(dmem_busy),
    .pc(pc), .id_en(id_en), .ex_en(ex_en), .wb_en(wb_en),
    .id_valid(id_valid), .ex_valid(ex_valid), .wb_valid(wb_valid), .stall_cause(stall_cause)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // hz: 0 none, 1 load rd5 vs rs2=5, 2 load rd0 vs rs1=0, 3 redirect,
  //     4 dmem busy, 5 busy+redirect, 6 redirect + load rd7 vs rs1=7
  typedef struct {
    logic        imem;
    int          hz;
    logic [31:0] tgt;
    logic [2:0]  en;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [2:0]  vld;
  } vec_t;

  vec_t vecs[24];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic im, int hz, logic [31:0] tgt, logic [2:0] en,
                              logic [1:0] cause, logic [31:0] pcx, logic [2:0] vld);
    vec_t v;
    v.imem = im; v.hz = hz; v.tgt = tgt; v.en = en; v.cause = cause; v.pc = pcx; v.vld = vld;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic im, int hz, logic [31:0] tgt);
    imem_valid   = im;
    id_rs1       = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd        = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
    ex_redirect  = 1'b0; ex_target = tgt; dmem_busy = 1'b0;
    case (hz)
      1: begin ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; ex_is_load = 1'b1; ex_reg_write = 1'b1; end
      2: begin ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; ex_is_load = 1'b1; ex_reg_write = 1'b1; end
      3: ex_redirect = 1'b1;
      4: dmem_busy = 1'b1;
      5: begin dmem_busy = 1'b1; ex_redirect = 1'b1; end
      6: begin ex_redirect = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
               ex_is_load = 1'b1; ex_reg_write = 1'b1; end
      default: ;
    endcase
  endtask

  initial begin
    int exp_ret, exp_stall, exp_flush;
    logic prev_wb;
    vecs[0]  = mk(1, 0, 0,             3'b111, 0, 32'h0000_0004, 3'b100);
    vecs[1]  = mk(1, 0, 0,             3'b111, 0, 32'h0000_0008, 3'b110);
    vecs[2]  = mk(1, 0, 0,             3'b111, 0, 32'h0000_000C, 3'b111);
    vecs[3]  = mk(1, 0, 0,             3'b111, 0, 32'h0000_0010, 3'b111);
    vecs[4]  = mk(1, 1, 0,             3'b011, 3, 32'h0000_0010, 3'b101);
    vecs[5]  = mk(1, 1, 0,             3'b111, 0, 32'h0000_0014, 3'b110);
    vecs[6]  = mk(1, 2, 0,             3'b111, 0, 32'h0000_0018, 3'b111);
    vecs[7]  = mk(1, 3, 32'h0000_0103, 3'b111, 2, 32'h0000_0102, 3'b001);
    vecs[8]  = mk(1, 0, 0,             3'b111, 0, 32'h0000_0106, 3'b100);
    vecs[9]  = mk(1, 3, 32'h0000_0500, 3'b111, 0, 32'h0000_010A, 3'b110);
    vecs[10] = mk(0, 0, 0,             3'b111, 0, 32'h0000_010A, 3'b011);
    vecs[11] = mk(1, 0, 0,             3'b111, 0, 32'h0000_010E, 3'b101);
    vecs[12] = mk(1, 0, 0,             3'b111, 0, 32'h0000_0112, 3'b110);
    vecs[13] = mk(1, 4, 0,             3'b000, 1, 32'h0000_0112, 3'b110);
    vecs[14] = mk(1, 5, 32'h0000_0900, 3'b000, 1, 32'h0000_0112, 3'b110);
    vecs[15] = mk(1, 4, 0,             3'b000, 1, 32'h0000_0112, 3'b110);
    vecs[16] = mk(1, 0, 0,             3'b111, 0, 32'h0000_0116, 3'b111);
    vecs[17] = mk(1, 6, 32'h0000_0200, 3'b111, 2, 32'h0000_0200, 3'b001);
    vecs[18] = mk(1, 1, 0,             3'b111, 0, 32'h0000_0204, 3'b100);
    vecs[19] = mk(1, 4, 0,             3'b111, 0, 32'h0000_0208, 3'b110);
    vecs[20] = mk(1, 3, 32'hFFFF_FFFD, 3'b111, 2, 32'hFFFF_FFFC, 3'b001);
    vecs[21] = mk(1, 0, 0,             3'b111, 0, 32'h0000_0000, 3'b100);
    vecs[22] = mk(1, 0, 0,             3'b111, 0, 32'h0000_0004, 3'b110);
    vecs[23] = mk(1, 4, 0,             3'b000, 1, 32'h0000_0004, 3'b110);

    rst = 1'b1;
    drive(1'b0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_pc", pc, 32'h0);
    chk("reset_valids", {29'd0, id_valid, ex_valid, wb_valid}, 32'h0);

    exp_ret = 0; exp_stall = 0; exp_flush = 0; prev_wb = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].imem, vecs[i].hz, vecs[i].tgt);
      #1;
      chk($sformatf("v%0d_en", i), {29'd0, id_en, ex_en, wb_en}, {29'd0, vecs[i].en});
      chk($sformatf("v%0d_cause", i), {30'd0, stall_cause}, {30'd0, vecs[i].cause});
      if (prev_wb) exp_ret++;
      if (vecs[i].cause == 2'd1 || vecs[i].cause == 2'd3) exp_stall++;
      if (vecs[i].cause == 2'd2) exp_flush++;
      prev_wb = vecs[i].vld[0];
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("v%0d_valid", i), {29'd0, id_valid, ex_valid, wb_valid}, {29'd0, vecs[i].vld});
    end

`ifdef PIPE_CTRL_PERF_EN
    chk("perf_retired", perf_retired, 32'(exp_ret));
    chk("perf_stall", perf_stall, 32'(exp_stall));
    chk("perf_flush", perf_flush, 32'(exp_flush));
`endif

    // reset asserted while a memory access is still outstanding
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_memwait_pc", pc, 32'h0);
    chk("rst_memwait_valids", {29'd0, id_valid, ex_valid, wb_valid}, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_perf", perf_retired | perf_stall | perf_flush, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_en", {29'd0, id_en, ex_en, wb_en}, 32'h7);
    chk("post_rst_cause", {30'd0, stall_cause}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_pc", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
